usb_cmd_rx: RTL and testbench

- Reader side of the CPU/USB byte link: pulls host-to-device bytes out of the USB CPU OUT endpoint.
- Frames the byte stream into 5-byte register-write commands and checks each command.
- Issues single-cycle register write strobes to the board register file (RST and control registers).
- Sits between the CPU port pins and the register block. It mirrors the data-to-CPU FIFO path, which handles the device-to-host direction.

---
 rtl/usb_cmd_rx_if.sv | 22 ++
 rtl/usb_cmd_rx.sv | 102 ++++++++++
 tb/tb_usb_cmd_rx.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_cmd_rx_if.sv
// CPU OUT-endpoint byte link plus the register-write side of usb_cmd_rx.
// The slave modport is the receiver; the master modport is the CPU/register-file side.
interface usb_cmd_rx_if;
    logic        flag;
    logic [7:0]  xdata;
    logic        xread;
    logic [7:0]  reg_adr;
    logic [15:0] reg_dat;
    logic        reg_we;
    logic [7:0]  err_cnt;
    logic        busy;

    modport master (
        output flag, xdata,
        input  xread, reg_adr, reg_dat, reg_we, err_cnt, busy
    );

    modport slave (
        input  flag, xdata,
        output xread, reg_adr, reg_dat, reg_we, err_cnt, busy
    );
endinterface

// File: rtl/usb_cmd_rx.sv
// Pulls host-to-device bytes from the CPU OUT FIFO and frames them into
// 5-byte checked register-write commands (SYNC, ADR, DLO, DHI, CSUM).
module usb_cmd_rx #(
    parameter logic [7:0]  SYNC    = 8'hBA,
    parameter logic [7:0]  CSEED   = 8'h5A,
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned TBITS   = 10
) (
    input  logic        clk,
    input  logic        reset,
    usb_cmd_rx_if.slave bus
);

    typedef enum logic [2:0] {HUNT, ADR, DLO, DHI, CSUM} state_t;

    state_t             state;
    logic               samp;
    logic [TBITS-1:0]   timer;
    logic [7:0]         a_r;
    logic [15:0]        d_r;
    logic               csum_ok_c;
    logic               timeout_c;

    assign csum_ok_c = (bus.xdata == (a_r ^ d_r[7:0] ^ d_r[15:8] ^ CSEED));
    assign timeout_c = (state != HUNT) && (timer == TBITS'(TIMEOUT));

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // samp marks the cycle after xread: the byte on xdata is taken at its closing edge,
    // which is also the earliest edge that may launch the next read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            samp        <= 1'b0;
            timer       <= '0;
            a_r         <= '0;
            d_r         <= '0;
            bus.xread   <= 1'b0;
            bus.reg_adr <= '0;
            bus.reg_dat <= '0;
            bus.reg_we  <= 1'b0;
            bus.err_cnt <= '0;
            bus.busy    <= 1'b0;
        end else begin
            bus.xread  <= bus.flag && !bus.xread;
            samp       <= bus.xread;
            bus.reg_we <= 1'b0;

            if (samp) begin
                timer <= '0;
                case (state)
                    HUNT: begin
                        if (bus.xdata == SYNC) begin
                            state    <= ADR;
                            bus.busy <= 1'b1;
                        end
                    end
                    ADR: begin
                        a_r   <= bus.xdata;
                        state <= DLO;
                    end
                    DLO: begin
                        d_r[7:0] <= bus.xdata;
                        state    <= DHI;
                    end
                    DHI: begin
                        d_r[15:8] <= bus.xdata;
                        state     <= CSUM;
                    end
                    CSUM: begin
                        state    <= HUNT;
                        bus.busy <= 1'b0;
                        if (csum_ok_c) begin
                            bus.reg_adr <= a_r;
                            bus.reg_dat <= d_r;
                            bus.reg_we  <= 1'b1;
                        end else begin
                            bus.err_cnt <= sat_inc(bus.err_cnt);
                        end
                    end
                    default: begin
                        state    <= HUNT;
                        bus.busy <= 1'b0;
                    end
                endcase
            end else if (timeout_c) begin
                // A byte sampled on the same edge takes priority over the timeout.
                state       <= HUNT;
                bus.busy    <= 1'b0;
                timer       <= '0;
                bus.err_cnt <= sat_inc(bus.err_cnt);
            end else if (state == HUNT) begin
                timer <= '0;
            end else begin
                timer <= timer + TBITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_usb_cmd_rx.sv
// Randomized bench for usb_cmd_rx: a CPU FIFO driver, a queue-based frame model
// compared every cycle, and literal expectations for the directed scenarios.
module tb_usb_cmd_rx;
    localparam logic [7:0] SYNC    = 8'hBA;
    localparam logic [7:0] CSEED   = 8'h5A;
    localparam int         TIMEOUT = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    usb_cmd_rx_if bus();

    usb_cmd_rx #(
        .SYNC(SYNC), .CSEED(CSEED), .TIMEOUT(TIMEOUT), .TBITS(10)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #12 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int we_seen = 0;

    logic [7:0] fifo[$];
    bit throttle = 1'b0;
    bit just_loaded = 1'b0;

    // Reference model: frame collected as a byte queue, outputs as plain variables.
    logic [7:0]  frame[$];
    bit          m_xread = 1'b0;
    bit          m_samp = 1'b0;
    bit          m_we = 1'b0;
    logic [7:0]  m_adr = 8'h00;
    logic [15:0] m_dat = 16'h0000;
    logic [7:0]  m_err = 8'h00;
    int          m_timer = 0;

    always @(posedge clk or posedge reset) begin : model
        bit         got;
        logic [7:0] b;
        if (reset) begin
            frame.delete();
            m_xread = 1'b0; m_samp = 1'b0; m_we = 1'b0;
            m_adr = 8'h00; m_dat = 16'h0000; m_err = 8'h00; m_timer = 0;
        end else begin
            got = m_samp;
            b = bus.xdata;
            m_samp = m_xread;
            m_xread = bus.flag && !m_xread;
            m_we = 1'b0;
            if (got) begin
                m_timer = 0;
                if (frame.size() == 0) begin
                    if (b == SYNC) frame.push_back(b);
                end else if (frame.size() == 4) begin
                    if ((frame[1] ^ frame[2] ^ frame[3] ^ CSEED) == b) begin
                        m_we = 1'b1;
                        m_adr = frame[1];
                        m_dat = {frame[3], frame[2]};
                    end else if (m_err != 8'hFF) begin
                        m_err = m_err + 8'd1;
                    end
                    frame.delete();
                end else begin
                    frame.push_back(b);
                end
            end else if (frame.size() == 0) begin
                m_timer = 0;
            end else if (m_timer == TIMEOUT) begin
                frame.delete();
                m_timer = 0;
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end else begin
                m_timer = m_timer + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: compare outputs against the model, then act as the CPU FIFO.
    task automatic step();
        @(negedge clk);
        chk("xread",   16'(bus.xread),   16'(m_xread));
        chk("reg_we",  16'(bus.reg_we),  16'(m_we));
        chk("reg_adr", 16'(bus.reg_adr), 16'(m_adr));
        chk("reg_dat", bus.reg_dat,      m_dat);
        chk("err_cnt", 16'(bus.err_cnt), 16'(m_err));
        chk("busy",    16'(bus.busy),    16'(frame.size() != 0));
        if (bus.reg_we) we_seen++;
        if (bus.xread) begin
            bus.xdata = (fifo.size() > 0) ? fifo.pop_front() : 8'($urandom);
            just_loaded = 1'b1;
        end else if (just_loaded) begin
            just_loaded = 1'b0;
        end else begin
            bus.xdata = 8'($urandom);
        end
        bus.flag = (fifo.size() > 0) && (!throttle || ($urandom_range(0, 1) == 1));
    endtask

    task automatic send(input logic [7:0] b0, b1, b2, b3, b4);
        fifo.push_back(b0); fifo.push_back(b1); fifo.push_back(b2);
        fifo.push_back(b3); fifo.push_back(b4);
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (fifo.size() > 0 && k < limit) begin
            step();
            k++;
        end
        chk("drain_left", 16'(fifo.size()), 16'd0);
        fifo.delete();
        repeat (6) step();
    endtask

    task automatic rand_frames(input int n, output int ngood);
        logic [7:0] a, lo, hi, cs, g;
        ngood = 0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                g = 8'($urandom);
                if (g == SYNC) g = 8'h00;
                fifo.push_back(g);
            end
            a  = 8'($urandom);
            lo = 8'($urandom);
            hi = 8'($urandom);
            cs = a ^ lo ^ hi ^ CSEED;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            else ngood++;
            send(SYNC, a, lo, hi, cs);
        end
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w0;
        int ng;
        bus.flag = 1'b0;
        bus.xdata = 8'h00;
        reset = 1'b1;
        repeat (3) step();
        chk("rst_xread",   16'(bus.xread),   16'd0);
        chk("rst_reg_we",  16'(bus.reg_we),  16'd0);
        chk("rst_reg_adr", 16'(bus.reg_adr), 16'd0);
        chk("rst_reg_dat", bus.reg_dat,      16'd0);
        chk("rst_err_cnt", 16'(bus.err_cnt), 16'd0);
        chk("rst_busy",    16'(bus.busy),    16'd0);
        reset = 1'b0;
        repeat (2) step();

        // Good frame at full rate
        w0 = we_seen;
        send(8'hBA, 8'h12, 8'h34, 8'h56, 8'h2A);
        drain(400);
        chk("good_adr", 16'(bus.reg_adr), 16'h0012);
        chk("good_dat", bus.reg_dat, 16'h5634);
        chk("good_err", 16'(bus.err_cnt), 16'd0);
        chk("good_we_count", 16'(we_seen - w0), 16'd1);

        // Garbage bytes before a frame
        w0 = we_seen;
        fifo.push_back(8'h00); fifo.push_back(8'hFF); fifo.push_back(8'h77);
        send(8'hBA, 8'h01, 8'h00, 8'h80, 8'hDB);
        drain(400);
        chk("garb_adr", 16'(bus.reg_adr), 16'h0001);
        chk("garb_dat", bus.reg_dat, 16'h8000);
        chk("garb_err", 16'(bus.err_cnt), 16'd0);
        chk("garb_we_count", 16'(we_seen - w0), 16'd1);

        // Bad checksum leaves registers, then a good frame
        w0 = we_seen;
        send(8'hBA, 8'h12, 8'h34, 8'h56, 8'h2B);
        drain(400);
        chk("bad_err", 16'(bus.err_cnt), 16'd1);
        chk("bad_adr", 16'(bus.reg_adr), 16'h0001);
        chk("bad_dat", bus.reg_dat, 16'h8000);
        chk("bad_we_count", 16'(we_seen - w0), 16'd0);
        send(8'hBA, 8'h12, 8'h34, 8'h56, 8'h2A);
        drain(400);
        chk("after_bad_adr", 16'(bus.reg_adr), 16'h0012);
        chk("after_bad_we_count", 16'(we_seen - w0), 16'd1);

        // Timeout mid-frame
        w0 = we_seen;
        fifo.push_back(8'hBA); fifo.push_back(8'h12);
        drain(400);
        chk("to_busy_before", 16'(bus.busy), 16'd1);
        repeat (TIMEOUT + 5) step();
        chk("to_busy", 16'(bus.busy), 16'd0);
        chk("to_err", 16'(bus.err_cnt), 16'd2);
        chk("to_we_count", 16'(we_seen - w0), 16'd0);
        send(8'hBA, 8'h01, 8'h00, 8'h80, 8'hDB);
        drain(400);
        chk("after_to_dat", bus.reg_dat, 16'h8000);
        chk("after_to_we_count", 16'(we_seen - w0), 16'd1);

        // SYNC value inside a frame is data
        send(8'hBA, 8'hBA, 8'hBA, 8'hBA, 8'hE0);
        drain(400);
        chk("insync_adr", 16'(bus.reg_adr), 16'h00BA);
        chk("insync_dat", bus.reg_dat, 16'hBABA);

        // Throttled flag, then back-to-back random frames
        throttle = 1'b1;
        w0 = we_seen;
        send(8'hBA, 8'h12, 8'h34, 8'h56, 8'h2A);
        drain(400);
        chk("thr_adr", 16'(bus.reg_adr), 16'h0012);
        chk("thr_dat", bus.reg_dat, 16'h5634);
        chk("thr_we_count", 16'(we_seen - w0), 16'd1);
        w0 = we_seen;
        rand_frames(30, ng);
        drain(3000);
        chk("rand_thr_we_count", 16'(we_seen - w0), 16'(ng));
        throttle = 1'b0;
        w0 = we_seen;
        rand_frames(30, ng);
        drain(3000);
        chk("rand_b2b_we_count", 16'(we_seen - w0), 16'(ng));

        // Async reset after the DHI byte
        send(8'hBA, 8'h12, 8'h34, 8'h56, 8'h2A);
        begin
            int k;
            k = 0;
            while (fifo.size() > 1 && k < 100) begin
                step();
                k++;
            end
        end
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("arst_xread",   16'(bus.xread),   16'd0);
        chk("arst_reg_we",  16'(bus.reg_we),  16'd0);
        chk("arst_reg_adr", 16'(bus.reg_adr), 16'd0);
        chk("arst_reg_dat", bus.reg_dat,      16'd0);
        chk("arst_err_cnt", 16'(bus.err_cnt), 16'd0);
        chk("arst_busy",    16'(bus.busy),    16'd0);
        fifo.delete();
        just_loaded = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        w0 = we_seen;
        repeat (20) step();
        chk("arst_we_count", 16'(we_seen - w0), 16'd0);

        // err_cnt saturation
        for (int i = 0; i < 254; i++)
            send(SYNC, 8'(i), 8'h00, 8'h00, 8'(i) ^ CSEED ^ 8'hFF);
        drain(4000);
        chk("sat_254", 16'(bus.err_cnt), 16'd254);
        for (int i = 0; i < 6; i++)
            send(SYNC, 8'(i), 8'h00, 8'h00, 8'(i) ^ CSEED ^ 8'hFF);
        drain(400);
        chk("sat_255", 16'(bus.err_cnt), 16'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
